cp0_reg: RTL and testbench

- Coprocessor-0 register file: the receiving end of the write-back CP0 channel driven by the MEM/WB pipeline register.
- Holds Count, Compare, Status, Cause, EPC, PRId and Config.
- Counts cycles, raises the timer interrupt, and samples external hardware interrupts into Cause.
- Provides one combinational read port to the EX stage (mfc0), with same-cycle bypass of the write-back write.

---
 rtl/cp0_reg_pkg.sv | 33 +++
 rtl/cp0_reg_if.sv | 22 ++
 rtl/cp0_reg.sv | 95 +++++++++
 tb/tb_cp0_reg.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: register numbers, Cause field masks and reset/constant values.
package cp0_reg_pkg;

  localparam int REG_W = 32;

  // CP0 register numbers as seen on the write-back and mfc0 address buses.
  typedef enum logic [4:0] {
    CP0_REG_COUNT   = 5'd9,
    CP0_REG_COMPARE = 5'd11,
    CP0_REG_STATUS  = 5'd12,
    CP0_REG_CAUSE   = 5'd13,
    CP0_REG_EPC     = 5'd14,
    CP0_REG_PRID    = 5'd15,
    CP0_REG_CONFIG  = 5'd16
  } cp0_reg_e;

  localparam logic [REG_W-1:0] ZERO_WORD = '0;

  // Cause: IP7..IP2 are hardware-sampled; IV, WP, IP1..IP0 are software-writable.
  localparam logic [REG_W-1:0] CAUSE_HW_IP_MASK = 32'h0000_fc00;
  localparam logic [REG_W-1:0] CAUSE_SW_MASK    = 32'h00c0_0300;

  localparam logic [REG_W-1:0] STATUS_RST_DEF = 32'h1000_0000;
  localparam logic [REG_W-1:0] PRID_VAL_DEF   = 32'h004c_0102;
  localparam logic [REG_W-1:0] CONFIG_VAL_DEF = 32'h0000_8000;

  // Merge software-writable Cause bits from new data with the current hardware IP bits.
  function automatic logic [REG_W-1:0] cause_merge(input logic [REG_W-1:0] data,
                                                   input logic [REG_W-1:0] cur);
    return (data & CAUSE_SW_MASK) | (cur & CAUSE_HW_IP_MASK);
  endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// Write-back CP0 write channel plus the EX-stage mfc0 read port.
interface cp0_reg_if;
  import cp0_reg_pkg::*;

  logic             wb_cp0_reg_we;
  logic [4:0]       wb_cp0_reg_write_addr;
  logic [REG_W-1:0] wb_cp0_reg_data;
  logic [4:0]       raddr;
  logic [REG_W-1:0] rdata;

  // Pipeline side: issues writes and read addresses, receives read data.
  modport master (
    output wb_cp0_reg_we, wb_cp0_reg_write_addr, wb_cp0_reg_data, raddr,
    input  rdata
  );

  // Register-file side.
  modport slave (
    input  wb_cp0_reg_we, wb_cp0_reg_write_addr, wb_cp0_reg_data, raddr,
    output rdata
  );
endinterface

// File: rtl/cp0_reg.sv
// CP0 register file: Count/Compare timer, Status, Cause with sampled hardware
// interrupts, EPC, constant PRId/Config, and a bypassed combinational read port.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [REG_W-1:0] PRID_VAL   = PRID_VAL_DEF,
  parameter logic [REG_W-1:0] CONFIG_VAL = CONFIG_VAL_DEF,
  parameter logic [REG_W-1:0] STATUS_RST = STATUS_RST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  cp0_reg_if.slave         bus,
  input  logic [5:0]       int_i,
  output logic [REG_W-1:0] count_o,
  output logic [REG_W-1:0] compare_o,
  output logic [REG_W-1:0] status_o,
  output logic [REG_W-1:0] cause_o,
  output logic [REG_W-1:0] epc_o,
  output logic             timer_int_o
);

  logic [REG_W-1:0] count_q, compare_q, status_q, cause_q, epc_q;
  logic             timer_q;
  logic [REG_W-1:0] rdata_c;

  // Register updates: reset wins over everything, then free-running count,
  // interrupt sampling and timer match, then the write-back write on top.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in this block override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= ZERO_WORD;
      compare_q <= ZERO_WORD;
      status_q  <= STATUS_RST;
      cause_q   <= ZERO_WORD;
      epc_q     <= ZERO_WORD;
      timer_q   <= 1'b0;
    end else begin
      count_q        <= count_q + 32'd1;
      cause_q[15:10] <= int_i;
      if (compare_q != ZERO_WORD && count_q == compare_q)
        timer_q <= 1'b1;
      if (bus.wb_cp0_reg_we) begin
        case (bus.wb_cp0_reg_write_addr)
          CP0_REG_COUNT:   count_q <= bus.wb_cp0_reg_data;
          CP0_REG_COMPARE: begin
            compare_q <= bus.wb_cp0_reg_data;
            timer_q   <= 1'b0;
          end
          CP0_REG_STATUS:  status_q <= bus.wb_cp0_reg_data;
          CP0_REG_CAUSE: begin
            cause_q[23:22] <= bus.wb_cp0_reg_data[23:22];
            cause_q[9:8]   <= bus.wb_cp0_reg_data[9:8];
          end
          CP0_REG_EPC:     epc_q <= bus.wb_cp0_reg_data;
          default: ;
        endcase
      end
    end
  end

  // mfc0 read port with same-cycle bypass of the write-back write.
  // NOTE: rdata_c gets a default before the case so no latch is inferred.
  always_comb begin
    rdata_c = ZERO_WORD;
    case (bus.raddr)
      CP0_REG_COUNT:   rdata_c = count_q;
      CP0_REG_COMPARE: rdata_c = compare_q;
      CP0_REG_STATUS:  rdata_c = status_q;
      CP0_REG_CAUSE:   rdata_c = cause_q;
      CP0_REG_EPC:     rdata_c = epc_q;
      CP0_REG_PRID:    rdata_c = PRID_VAL;
      CP0_REG_CONFIG:  rdata_c = CONFIG_VAL;
      default: ;
    endcase
    if (bus.wb_cp0_reg_we && bus.wb_cp0_reg_write_addr == bus.raddr) begin
      case (bus.raddr)
        CP0_REG_COUNT, CP0_REG_COMPARE, CP0_REG_STATUS, CP0_REG_EPC:
          rdata_c = bus.wb_cp0_reg_data;
        CP0_REG_CAUSE:
          rdata_c = cause_merge(bus.wb_cp0_reg_data, cause_q);
        default: ;
      endcase
    end
  end

  assign bus.rdata   = rdata_c;
  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed self-checking bench for cp0_reg.
module tb_cp0_reg;
  import cp0_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o;
  logic        timer_int_o;
  int          checks = 0;
  int          failures = 0;

  cp0_reg_if bus();

  cp0_reg dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .int_i       (int_i),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .status_o    (status_o),
    .cause_o     (cause_o),
    .epc_o       (epc_o),
    .timer_int_o (timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_cp0_reg_we         = 1'b1;
    bus.wb_cp0_reg_write_addr = addr;
    bus.wb_cp0_reg_data       = data;
  endtask

  task automatic idle();
    bus.wb_cp0_reg_we         = 1'b0;
    bus.wb_cp0_reg_write_addr = 5'd0;
    bus.wb_cp0_reg_data       = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    int_i = 6'd0;
    bus.raddr = 5'd0;
    idle();

    // 1. Reset state, counting, constants.
    step(); step();
    check("rst_count", count_o, 32'd0);
    check("rst_status", status_o, 32'h1000_0000);
    check("rst_timer", {31'd0, timer_int_o}, 32'd0);
    check("rst_cause", cause_o, 32'd0);
    rst = 1'b0;
    step();
    check("count_1", count_o, 32'd1);
    step();
    check("count_2", count_o, 32'd2);
    bus.raddr = 5'd15; #1;
    check("rd_prid", bus.rdata, 32'h004c_0102);
    bus.raddr = 5'd16; #1;
    check("rd_config", bus.rdata, 32'h0000_8000);
    bus.raddr = 5'd3; #1;
    check("rd_unused", bus.rdata, 32'd0);
    bus.raddr = 5'd9; #1;
    check("rd_count", bus.rdata, 32'd2);

    // 2. Compare = 5 written at Count = 0; timer fires on the Count==5 edge.
    rst = 1'b1; step(); rst = 1'b0;
    wr(5'd11, 32'd5); step(); idle();
    check("cmp_written", compare_o, 32'd5);
    step(); step(); step(); step();
    check("cmp_count5", count_o, 32'd5);
    check("cmp_pre_fire", {31'd0, timer_int_o}, 32'd0);
    step();
    check("cmp_fire", {31'd0, timer_int_o}, 32'd1);
    step(); step();
    check("cmp_hold", {31'd0, timer_int_o}, 32'd1);
    wr(5'd11, 32'd100); step(); idle();
    check("cmp_clear", {31'd0, timer_int_o}, 32'd0);
    check("cmp_100", compare_o, 32'd100);
    // Compare write coinciding with a match: write wins.
    wr(5'd9, 32'd99); step(); idle();
    check("cnt_99", count_o, 32'd99);
    step();
    check("cnt_100", count_o, 32'd100);
    wr(5'd11, 32'd200); step(); idle();
    check("cmp_write_wins", {31'd0, timer_int_o}, 32'd0);
    step();
    check("cmp_no_late_fire", {31'd0, timer_int_o}, 32'd0);

    // 3. Count wrap with Compare = 0.
    rst = 1'b1; step(); rst = 1'b0;
    wr(5'd9, 32'hffff_fffe); step(); idle();
    check("wrap_fe", count_o, 32'hffff_fffe);
    step();
    check("wrap_ff", count_o, 32'hffff_ffff);
    step();
    check("wrap_00", count_o, 32'd0);
    step();
    check("wrap_01", count_o, 32'd1);
    check("cmp0_no_fire", {31'd0, timer_int_o}, 32'd0);

    // 4. Cause sampling and masked writes, including bypassed read.
    int_i = 6'b100001; step();
    check("cause_ip", cause_o, 32'h0000_8400);
    wr(5'd13, 32'hffff_ffff); bus.raddr = 5'd13; #1;
    check("cause_bypass", bus.rdata, 32'h00c0_8700);
    step(); idle();
    check("cause_wr", cause_o, 32'h00c0_8700);
    int_i = 6'd0; step();
    check("cause_ip_clr", cause_o, 32'h00c0_0300);

    // 5. EPC bypass, PRId never bypassed, Status full write.
    wr(5'd14, 32'h8000_0180); bus.raddr = 5'd14; #1;
    check("epc_bypass", bus.rdata, 32'h8000_0180);
    step(); idle();
    check("epc_o", epc_o, 32'h8000_0180);
    wr(5'd15, 32'h1234_5678); bus.raddr = 5'd15; #1;
    check("prid_no_bypass", bus.rdata, 32'h004c_0102);
    step();
    wr(5'd12, 32'hdead_beef); step(); idle();
    check("status_wr", status_o, 32'hdead_beef);

    // 6. Reset overrides a Status write while the timer is high.
    wr(5'd9, 32'd10); step();
    wr(5'd11, 32'd11); step(); idle();
    step();
    check("t6_timer_hi", {31'd0, timer_int_o}, 32'd1);
    rst = 1'b1; wr(5'd12, 32'h0000_ff01); step(); idle(); rst = 1'b0;
    check("t6_status", status_o, 32'h1000_0000);
    check("t6_timer", {31'd0, timer_int_o}, 32'd0);
    check("t6_count", count_o, 32'd0);
    check("t6_compare", compare_o, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
